// File: rtl/ifu_fetch_queue_ctrl.sv
// ifu_fetch_queue_ctrl
//   Occupancy and pointer controller for the IFU fetch queue. The queue holds
//   DEPTH entries arranged as NUM_BANKS banks x BANK_DEPTH rows. Entry index
//   bits [2:0] select the bank and [4:3] select the row. Fetch writes a group
//   of up to NUM_BANKS instructions per cycle. Decode reads up to RD_PORTS
//   instructions per cycle. Flush empties the queue.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             redirect; discards all queue contents
//   fetch_valid       fetch group presented this cycle
//   fetch_inst_num    number of valid instructions in the group (0..8)
//   fetch_ready       room for a full 8-instruction group
//   push_en           group accepted this cycle
//   wr_ptr            entry index of inst0 of the group
//   wr_bank_ptr       one-hot bank of wr_ptr
//   dec_ready_num     instructions decode can take this cycle (0..4)
//   rd_ptr            entry index of the oldest instruction
//   rd_bank_ptr       one-hot bank of rd_ptr
//   out_valid         thermometer of the instructions available to decode
//   deq_num           instructions popped this cycle
//   count             occupancy (0..DEPTH)
//   empty, full       count==0, count==DEPTH
module ifu_fetch_queue_ctrl #(
   parameter int unsigned NUM_BANKS  = 8,
   parameter int unsigned BANK_DEPTH = 4,
   parameter int unsigned DEPTH      = NUM_BANKS * BANK_DEPTH,
   parameter int unsigned RD_PORTS   = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               flush,
   input  logic                               fetch_valid,
   input  logic [$clog2(NUM_BANKS+1)-1:0]     fetch_inst_num,
   output logic                               fetch_ready,
   output logic                               push_en,
   output logic [$clog2(DEPTH)-1:0]           wr_ptr,
   output logic [NUM_BANKS-1:0]               wr_bank_ptr,
   input  logic [$clog2(RD_PORTS+1)-1:0]      dec_ready_num,
   output logic [$clog2(DEPTH)-1:0]           rd_ptr,
   output logic [NUM_BANKS-1:0]               rd_bank_ptr,
   output logic [RD_PORTS-1:0]                out_valid,
   output logic [$clog2(RD_PORTS+1)-1:0]      deq_num,
   output logic [$clog2(DEPTH+1)-1:0]         count,
   output logic                               empty,
   output logic                               full
);

   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned CW  = $clog2(DEPTH+1);
   localparam int unsigned BW  = $clog2(NUM_BANKS);
   localparam int unsigned NW  = $clog2(NUM_BANKS+1);
   localparam int unsigned DW  = $clog2(RD_PORTS+1);

   logic [CW-1:0]        count_q, count_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [NUM_BANKS-1:0] wr_bank_q, wr_bank_d;
   logic [NUM_BANKS-1:0] rd_bank_q, rd_bank_d;

   logic [NW-1:0]        push_num;
   logic [DW-1:0]        dec_lim;
   logic [CW:0]          count_wide;

   // Rotating the doubled vector left and keeping the upper half gives a
   // rotate-left. A group of NUM_BANKS instructions rotates by 0, as expected.
   function automatic logic [NUM_BANKS-1:0] rotl(input logic [NUM_BANKS-1:0] v,
                                                 input logic [BW-1:0]        amt);
      logic [2*NUM_BANKS-1:0] t;
      t = {v, v} << amt;
      return t[2*NUM_BANKS-1:NUM_BANKS];
   endfunction

   // Outputs depend on the registered state plus the current inputs.
   // Nothing that is pushed this cycle can be seen on the read side until the next cycle.
   always_comb begin
      fetch_ready = (count_q <= CW'(DEPTH - NUM_BANKS));
      push_en     = fetch_valid & fetch_ready & ~flush;
      push_num    = push_en ? fetch_inst_num : '0;
      dec_lim     = (dec_ready_num > DW'(RD_PORTS)) ? DW'(RD_PORTS) : dec_ready_num;
      deq_num     = '0;
      out_valid   = '0;
      if (!flush) begin
         deq_num = (CW'(dec_lim) < count_q) ? dec_lim : DW'(count_q);
         for (int unsigned i = 0; i < RD_PORTS; i++) begin
            out_valid[i] = (count_q > CW'(i));
         end
      end
   end

   always_comb begin
      count_wide = {1'b0, count_q} + (CW+1)'(push_num) - (CW+1)'(deq_num);
      count_d    = count_q + CW'(push_num) - CW'(deq_num);
      wr_ptr_d   = wr_ptr_q + PW'(push_num);
      rd_ptr_d   = rd_ptr_q + PW'(deq_num);
      wr_bank_d  = rotl(wr_bank_q, BW'(push_num));
      rd_bank_d  = rotl(rd_bank_q, BW'(deq_num));
      if (flush) begin
         count_d   = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         wr_bank_d = NUM_BANKS'(1);
         rd_bank_d = NUM_BANKS'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         wr_bank_q <= NUM_BANKS'(1);
         rd_bank_q <= NUM_BANKS'(1);
      end else begin
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
      end
   end

   assign wr_ptr      = wr_ptr_q;
   assign rd_ptr      = rd_ptr_q;
   assign wr_bank_ptr = wr_bank_q;
   assign rd_bank_ptr = rd_bank_q;
   assign count       = count_q;
   assign empty       = (count_q == '0);
   assign full        = (count_q == CW'(DEPTH));

   a_fetch_num: assert property (@(posedge clk) disable iff (rst)
      fetch_valid |-> (fetch_inst_num <= NW'(NUM_BANKS)));
   a_dec_num: assert property (@(posedge clk) disable iff (rst)
      dec_ready_num <= DW'(RD_PORTS));
   // With one extra bit, an underflow wraps to a large value, so one bound catches both directions.
   a_count_range: assert property (@(posedge clk) disable iff (rst)
      count_wide <= (CW+1)'(DEPTH));
   a_bank_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot(wr_bank_q) && $onehot(rd_bank_q));
   a_bank_align: assert property (@(posedge clk) disable iff (rst)
      (wr_bank_q == rotl(NUM_BANKS'(1), wr_ptr_q[BW-1:0])) &&
      (rd_bank_q == rotl(NUM_BANKS'(1), rd_ptr_q[BW-1:0])));

endmodule
